// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, ROM addressing, one-entry valid/ready output stage.
// Optional halt-on-EBREAK behaviour is enabled by defining FETCH_HALT_EN.
module instr_fetch_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              halt_o,
    output logic [15:0]       retire_cnt_o
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;
`ifdef FETCH_HALT_EN
    localparam logic [31:0] EBREAK = 32'h00100073;
`endif

    logic [0:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] redirect_target;
    logic              load;
    logic              xfer;

    assign load            = !valid_o || ready_i;
    assign xfer            = valid_o && ready_i;
    assign redirect_target = redirect_addr_i & ~ADDR_W'(3);
    assign rom_addr_o      = fetch_pc;

`ifdef FETCH_HALT_EN
    assign halt_o = (state == S_HALT);
`else
    assign halt_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_RUN;
            fetch_pc     <= RESET_PC;
            instr_o      <= '0;
            pc_o         <= '0;
            valid_o      <= 1'b0;
            retire_cnt_o <= '0;
        end else begin
            if (xfer) begin
                retire_cnt_o <= retire_cnt_o + 16'd1;
            end
            // Redirect flushes the output stage regardless of state or handshake.
            if (redirect_i) begin
                fetch_pc <= redirect_target;
                valid_o  <= 1'b0;
                state    <= S_RUN;
            end else if (state == S_RUN) begin
                if (load) begin
                    instr_o <= rom_data_i;
                    pc_o    <= fetch_pc;
                    valid_o <= 1'b1;
`ifdef FETCH_HALT_EN
                    if (rom_data_i == EBREAK) begin
                        state <= S_HALT;
                    end else begin
                        fetch_pc <= fetch_pc + ADDR_W'(4);
                    end
`else
                    fetch_pc <= fetch_pc + ADDR_W'(4);
`endif
                end
            end else if (xfer) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus randomized run vs a reference model.
module tb_instr_fetch_ctrl;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rom_addr, redirect_addr, pc;
    logic [31:0] rom_data, instr;
    logic        redirect = 1'b0, ready = 1'b0, valid, halt;
    logic [15:0] retire_cnt;

    logic [7:0]  rom_addr_w, pc_w;
    logic [31:0] rom_data_w, instr_w;
    logic        valid_w, halt_w;
    logic [15:0] retire_cnt_w;
    logic        ready_w = 1'b1, redirect_w = 1'b0;
    logic [7:0]  redirect_addr_w = 8'h00;

    logic [31:0] rom [0:63];
    assign rom_data   = rom[rom_addr[7:2]];
    assign rom_data_w = rom[rom_addr_w[7:2]];

    int total = 0;
    int bad   = 0;

    // Reference model state (architectural view of the fetch stage)
    logic [7:0]  m_fpc, m_pc;
    logic [31:0] m_instr;
    logic        m_valid, m_halt;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .redirect_i(redirect), .redirect_addr_i(redirect_addr), .instr_o(instr),
        .pc_o(pc), .valid_o(valid), .ready_i(ready), .halt_o(halt),
        .retire_cnt_o(retire_cnt)
    );

    instr_fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'hF8)) dut_w (
        .clk_i(clk), .rst_n_i(rst_n), .rom_addr_o(rom_addr_w), .rom_data_i(rom_data_w),
        .redirect_i(redirect_w), .redirect_addr_i(redirect_addr_w), .instr_o(instr_w),
        .pc_o(pc_w), .valid_o(valid_w), .ready_i(ready_w), .halt_o(halt_w),
        .retire_cnt_o(retire_cnt_w)
    );

    task automatic load_default_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[0] = 32'h00000000;
        rom[1] = 32'h00108093;
        rom[2] = 32'h001080B3;
        rom[3] = 32'h001080B3;
        rom[4] = 32'h55555555;
        for (int i = 5; i < 64; i++) begin
            rom[i] = $urandom;
            if (rom[i] == EBREAK) rom[i] = 32'h13;
        end
    endtask

    task automatic model_reset();
        m_fpc = 8'h00; m_pc = 8'h00; m_instr = 32'h0;
        m_valid = 1'b0; m_halt = 1'b0; m_cnt = 16'h0;
    endtask

    // One transaction-level step of the fetch stage, using the rules of the handshake.
    task automatic model_step(input bit rdy, input bit redir, input logic [7:0] raddr);
        bit accepted, can_take;
        logic [31:0] w;
        accepted = m_valid && rdy;
        can_take = !m_valid || rdy;
        if (accepted) m_cnt = m_cnt + 16'd1;
        if (redir) begin
            m_fpc   = {raddr[7:2], 2'b00};
            m_valid = 1'b0;
            m_halt  = 1'b0;
        end else if (!m_halt) begin
            if (can_take) begin
                w       = rom[m_fpc[7:2]];
                m_instr = w;
                m_pc    = m_fpc;
                m_valid = 1'b1;
                if (HALT_EN && w == EBREAK) m_halt = 1'b1;
                else m_fpc = m_fpc + 8'd4;
            end
        end else if (accepted) begin
            m_valid = 1'b0;
        end
    endtask

    // Drive inputs after a falling edge, clock once, return at the next falling edge.
    task automatic cycle(input bit rdy, input bit redir, input logic [7:0] raddr);
        ready = rdy; redirect = redir; redirect_addr = raddr;
        model_step(rdy, redir, raddr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (valid !== 1'b0 || instr !== 32'h0 || pc !== 8'h00 || halt !== 1'b0 ||
            retire_cnt !== 16'h0 || rom_addr !== 8'h00) begin
            bad++;
            $display("FAIL reset_state got v=%b i=%h pc=%h h=%b c=%h a=%h exp all zero",
                     valid, instr, pc, halt, retire_cnt, rom_addr);
        end
        total++;
        if (rom_addr_w !== 8'hF8) begin
            bad++;
            $display("FAIL reset_pc_param got=%h exp=f8", rom_addr_w);
        end
        cycle(1'b0, 1'b0, 8'h00);
        total++;
        if (valid !== 1'b1 || instr !== 32'h0 || pc !== 8'h00) begin
            bad++;
            $display("FAIL first_fetch got v=%b i=%h pc=%h exp v=1 i=0 pc=00", valid, instr, pc);
        end
    endtask

    task automatic test_sequence();
        logic [7:0]  exp_pc [4];
        logic [31:0] exp_i  [4];
        exp_pc = '{8'h00, 8'h04, 8'h08, 8'h0C};
        exp_i  = '{32'h00000000, 32'h00108093, 32'h001080B3, 32'h001080B3};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 8'h00);
            total++;
            if (valid !== 1'b1 || pc !== exp_pc[k] || instr !== exp_i[k]) begin
                bad++;
                $display("FAIL seq_%0d got v=%b pc=%h i=%h exp pc=%h i=%h",
                         k, valid, pc, instr, exp_pc[k], exp_i[k]);
            end
        end
        cycle(1'b1, 1'b0, 8'h00);
        total++;
        if (retire_cnt !== 16'd4) begin
            bad++;
            $display("FAIL seq_retire got=%0d exp=4", retire_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 8'h00);
            total++;
            if (valid !== 1'b1 || pc !== 8'h04 || instr !== 32'h00108093 || rom_addr !== 8'h08) begin
                bad++;
                $display("FAIL stall_hold_%0d got v=%b pc=%h i=%h a=%h exp pc=04 i=00108093 a=08",
                         k, valid, pc, instr, rom_addr);
            end
        end
        cycle(1'b1, 1'b0, 8'h00);
        total++;
        if (pc !== 8'h08 || instr !== 32'h001080B3 || retire_cnt !== 16'd2) begin
            bad++;
            $display("FAIL stall_resume got pc=%h i=%h c=%0d exp pc=08 i=001080b3 c=2",
                     pc, instr, retire_cnt);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h13);
        total++;
        if (valid !== 1'b0 || rom_addr !== 8'h10) begin
            bad++;
            $display("FAIL redirect_flush got v=%b a=%h exp v=0 a=10", valid, rom_addr);
        end
        cycle(1'b0, 1'b0, 8'h00);
        total++;
        if (valid !== 1'b1 || pc !== 8'h10 || instr !== 32'h55555555) begin
            bad++;
            $display("FAIL redirect_target got v=%b pc=%h i=%h exp v=1 pc=10 i=55555555",
                     valid, pc, instr);
        end
        cycle(1'b1, 1'b1, 8'h04);
        total++;
        if (valid !== 1'b0 || retire_cnt !== 16'd1) begin
            bad++;
            $display("FAIL redirect_xfer_count got v=%b c=%0d exp v=0 c=1", valid, retire_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [4];
        exp_pc = '{8'hF8, 8'hFC, 8'h00, 8'h04};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 8'h00);
            total++;
            if (valid_w !== 1'b1 || pc_w !== exp_pc[k] || instr_w !== rom[exp_pc[k][7:2]]) begin
                bad++;
                $display("FAIL wrap_%0d got pc=%h v=%b exp pc=%h", k, pc_w, valid_w, exp_pc[k]);
            end
        end
    endtask

    task automatic test_halt();
        rom[2] = EBREAK;
        do_reset();
        repeat (3) cycle(1'b1, 1'b0, 8'h00);
        total++;
        if (valid !== 1'b1 || pc !== 8'h08 || instr !== EBREAK || halt !== HALT_EN) begin
            bad++;
            $display("FAIL halt_ebreak got v=%b pc=%h i=%h h=%b exp pc=08 h=%b",
                     valid, pc, instr, halt, HALT_EN);
        end
        cycle(1'b1, 1'b0, 8'h00);
        if (HALT_EN) begin
            for (int k = 0; k < 10; k++) begin
                total++;
                if (valid !== 1'b0 || halt !== 1'b1 || rom_addr !== 8'h08) begin
                    bad++;
                    $display("FAIL halt_frozen_%0d got v=%b h=%b a=%h exp v=0 h=1 a=08",
                             k, valid, halt, rom_addr);
                end
                cycle(1'b1, 1'b0, 8'h00);
            end
        end else begin
            total++;
            if (valid !== 1'b1 || pc !== 8'h0C || halt !== 1'b0) begin
                bad++;
                $display("FAIL nohalt_continue got v=%b pc=%h h=%b exp v=1 pc=0c h=0",
                         valid, pc, halt);
            end
        end
        cycle(1'b1, 1'b1, 8'h00);
        total++;
        if (halt !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL halt_exit got h=%b v=%b exp h=0 v=0", halt, valid);
        end
        cycle(1'b1, 1'b0, 8'h00);
        total++;
        if (valid !== 1'b1 || pc !== 8'h00 || halt !== 1'b0) begin
            bad++;
            $display("FAIL halt_resume got v=%b pc=%h h=%b exp v=1 pc=00 h=0", valid, pc, halt);
        end
        load_default_rom();
    endtask

    task automatic test_random();
        int unsigned n_err;
        n_err = 0;
        for (int i = 5; i < 64; i++) rom[i] = $urandom;
        rom[$urandom_range(8, 63)] = EBREAK;
        do_reset();
        for (int unsigned k = 0; k < 600; k++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 8'($urandom));
            total++;
            if (valid !== m_valid || halt !== m_halt || retire_cnt !== m_cnt ||
                rom_addr !== m_fpc || (m_valid && (pc !== m_pc || instr !== m_instr))) begin
                bad++;
                n_err++;
                if (n_err <= 8)
                    $display("FAIL random_%0d got v=%b h=%b c=%h a=%h pc=%h i=%h exp v=%b h=%b c=%h a=%h pc=%h i=%h",
                             k, valid, halt, retire_cnt, rom_addr, pc, instr,
                             m_valid, m_halt, m_cnt, m_fpc, m_pc, m_instr);
            end
        end
        load_default_rom();
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (valid !== 1'b0 || instr !== 32'h0 || pc !== 8'h00 || halt !== 1'b0 ||
            retire_cnt !== 16'h0 || rom_addr !== 8'h00 || rom_addr_w !== 8'hF8) begin
            bad++;
            $display("FAIL async_reset_stall got v=%b i=%h pc=%h h=%b c=%h a=%h aw=%h",
                     valid, instr, pc, halt, retire_cnt, rom_addr, rom_addr_w);
        end
        @(negedge clk);
        do_reset();
        repeat (2) cycle(1'b1, 1'b0, 8'h00);
        ready = 1'b1; redirect = 1'b1; redirect_addr = 8'h40;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (valid !== 1'b0 || retire_cnt !== 16'h0 || rom_addr !== 8'h00 || pc !== 8'h00) begin
            bad++;
            $display("FAIL async_reset_redirect got v=%b c=%h a=%h pc=%h exp all zero",
                     valid, retire_cnt, rom_addr, pc);
        end
        @(negedge clk);
    endtask

    task automatic test_retire_wrap();
        do_reset();
        for (int unsigned k = 0; k < 65536; k++) cycle(1'b1, 1'b0, 8'h00);
        total++;
        if (retire_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL retire_max got=%h exp=ffff", retire_cnt);
        end
        cycle(1'b1, 1'b0, 8'h00);
        total++;
        if (retire_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL retire_wrap got=%h exp=0000", retire_cnt);
        end
    endtask

    initial begin
        load_default_rom();
        model_reset();
        @(negedge clk);
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_random();
        test_async_reset();
        test_retire_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
